// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the immediate-generation pipeline.
// Opcode values are inst[6:2] of a 32-bit RISC-V instruction word.
package imm_pkg;

  // FMT_NONE is zero so that a cleared entry already reads as "no immediate".
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } imm_fmt_e;

  localparam logic [4:0] OPC_LOAD      = 5'b00000;
  localparam logic [4:0] OPC_LOAD_FP   = 5'b00001;
  localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
  localparam logic [4:0] OPC_AUIPC     = 5'b00101;
  localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
  localparam logic [4:0] OPC_STORE     = 5'b01000;
  localparam logic [4:0] OPC_STORE_FP  = 5'b01001;
  localparam logic [4:0] OPC_LUI       = 5'b01101;
  localparam logic [4:0] OPC_BRANCH    = 5'b11000;
  localparam logic [4:0] OPC_JALR      = 5'b11001;
  localparam logic [4:0] OPC_JAL       = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM    = 5'b11100;

  localparam logic [1:0] INST_LEN_32 = 2'b11;

endpackage

// File: rtl/imm_decode.sv
// Combinational opcode classification and immediate extraction.
// All formats are built as a 32-bit sign-correct value, then widened to XLEN.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            illegal
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_decode: XLEN must be 32 or 64");
  end

  logic [31:0] imm32;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    fmt   = FMT_NONE;
    imm32 = '0;

    if (inst[1:0] == INST_LEN_32) begin
      case (inst[6:2])
        OPC_LOAD, OPC_LOAD_FP, OPC_OP_IMM, OPC_JALR: fmt = FMT_I;
        OPC_OP_IMM_32:                               fmt = (XLEN == 64) ? FMT_I : FMT_NONE;
        OPC_STORE, OPC_STORE_FP:                     fmt = FMT_S;
        OPC_BRANCH:                                  fmt = FMT_B;
        OPC_LUI, OPC_AUIPC:                          fmt = FMT_U;
        OPC_JAL:                                     fmt = FMT_J;
        OPC_SYSTEM:                                  fmt = FMT_Z;
        default:                                     fmt = FMT_NONE;
      endcase
    end

    case (fmt)
      FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   imm32 = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   imm32 = {inst[31:12], 12'b0};
      FMT_J:   imm32 = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      FMT_Z:   imm32 = {27'b0, inst[19:15]};
      default: imm32 = '0;
    endcase
  end

  // Zimm has bit 31 clear, so sign-extension doubles as its zero-extension.
  assign imm     = XLEN'($signed(imm32));
  assign illegal = (fmt == FMT_NONE);

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode stage wrapped in an output register plus a one-entry skid register,
// giving full throughput with a flop-driven in_ready.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_fmt_e         fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_illegal;
  entry_t          dec_entry;

  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q, in_ready_d;
  logic   accept;

  imm_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .inst    (in_inst),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  assign dec_entry = '{imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal, tag: in_tag};
  assign accept    = in_valid & in_ready_q;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;

    if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) out_d = dec_entry;
      end
    end else if (accept) begin
      // Output is stalled: park the new entry so in_ready can drop a cycle later.
      skid_d       = dec_entry;
      skid_valid_d = 1'b1;
    end

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end

    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      // NOTE: payload flops are reset as well, because their reset value is visible on the ports.
      out_q        <= '0;
      skid_q       <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values.
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      out_q        <= out_d;
      skid_q       <= skid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_illegal = out_q.illegal;
  assign out_tag     = out_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: XLEN=32 and XLEN=64 instances share one stimulus stream
// and are compared against a queue-based reference built from the decode rules.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_tag;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32, out_tag32;
  logic [2:0]  out_fmt32;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [31:0] out_tag64;
  logic [2:0]  out_fmt64;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] tag;
  } ent_t;
  ent_t q[$];
  bit   fire_in, fire_out;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u_dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_fmt(out_fmt32), .out_illegal(out_illegal32), .out_tag(out_tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_illegal64), .out_tag(out_tag64)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic longint sx(input longint val, input int bits);
    longint half = longint'(1) << (bits - 1);
    return (val >= half) ? val - (longint'(1) << bits) : val;
  endfunction

  // Reference decode: field values treated as integers, scaled and signed arithmetically.
  function automatic void ref_dec(input logic [31:0] inst, input int xlen,
                                  output logic [63:0] imm, output logic [2:0] fmt,
                                  output logic ill);
    longint v = 0;
    fmt = FMT_NONE;
    if (inst[1:0] == 2'b11) begin
      case (inst[6:2])
        5'b00000, 5'b00001, 5'b00100, 5'b11001: fmt = FMT_I;
        5'b00110: if (xlen == 64) fmt = FMT_I;
        5'b01000, 5'b01001: fmt = FMT_S;
        5'b11000: fmt = FMT_B;
        5'b01101, 5'b00101: fmt = FMT_U;
        5'b11011: fmt = FMT_J;
        5'b11100: fmt = FMT_Z;
        default: fmt = FMT_NONE;
      endcase
    end
    case (fmt)
      FMT_I: v = sx(longint'(inst[31:20]), 12);
      FMT_S: v = sx(longint'({inst[31:25], inst[11:7]}), 12);
      FMT_B: v = sx(longint'({inst[31], inst[7], inst[30:25], inst[11:8]}), 12) * 2;
      FMT_J: v = sx(longint'({inst[31], inst[19:12], inst[20], inst[30:21]}), 20) * 2;
      FMT_U: v = sx(longint'(inst[31:12]), 20) * 4096;
      FMT_Z: v = longint'(inst[19:15]);
      default: v = 0;
    endcase
    ill = (fmt == FMT_NONE);
    imm = 64'(v);
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [4:0] opcs [0:11] = '{5'b00000, 5'b00001, 5'b00100, 5'b00101, 5'b00110, 5'b01000,
                                5'b01001, 5'b01101, 5'b11000, 5'b11001, 5'b11011, 5'b11100};
    logic [31:0] w = $urandom;
    int r = $urandom_range(0, 15);
    if (r < 12) w[6:0] = {opcs[r], 2'b11};
    else if (r == 12) w[1:0] = 2'($urandom_range(0, 2));
    return w;
  endfunction

  // One clock: check both DUTs against the model at negedge, then advance the model.
  task automatic step();
    logic [63:0] e_imm;
    logic [2:0]  e_fmt;
    logic        e_ill;
    bit          exp_v, exp_r;
    @(negedge clk);
    exp_v = (q.size() > 0);
    exp_r = (q.size() < 2);
    checks++; if (out_valid32 !== exp_v) begin errors++; $display("FAIL out_valid32: got %b want %b", out_valid32, exp_v); end
    checks++; if (out_valid64 !== exp_v) begin errors++; $display("FAIL out_valid64: got %b want %b", out_valid64, exp_v); end
    checks++; if (in_ready32 !== exp_r) begin errors++; $display("FAIL in_ready32: got %b want %b", in_ready32, exp_r); end
    checks++; if (in_ready64 !== exp_r) begin errors++; $display("FAIL in_ready64: got %b want %b", in_ready64, exp_r); end
    if (exp_v) begin
      ref_dec(q[0].inst, 32, e_imm, e_fmt, e_ill);
      checks++;
      if (out_imm32 !== e_imm[31:0] || out_fmt32 !== e_fmt || out_illegal32 !== e_ill || out_tag32 !== q[0].tag) begin
        errors++;
        $display("FAIL entry32 inst=%h: got imm=%h fmt=%0d ill=%b tag=%h want imm=%h fmt=%0d ill=%b tag=%h",
                 q[0].inst, out_imm32, out_fmt32, out_illegal32, out_tag32, e_imm[31:0], e_fmt, e_ill, q[0].tag);
      end
      ref_dec(q[0].inst, 64, e_imm, e_fmt, e_ill);
      checks++;
      if (out_imm64 !== e_imm || out_fmt64 !== e_fmt || out_illegal64 !== e_ill || out_tag64 !== q[0].tag) begin
        errors++;
        $display("FAIL entry64 inst=%h: got imm=%h fmt=%0d ill=%b tag=%h want imm=%h fmt=%0d ill=%b tag=%h",
                 q[0].inst, out_imm64, out_fmt64, out_illegal64, out_tag64, e_imm, e_fmt, e_ill, q[0].tag);
      end
    end
    fire_out = exp_v && out_ready;
    fire_in  = in_valid && exp_r;
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (fire_out) void'(q.pop_front());
      if (fire_in) q.push_back('{in_inst, in_tag});
    end
    #1;
  endtask

  task automatic test_reset();
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) #2;
      else begin @(posedge clk); #1; end
      checks++; if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b/%b want 0", out_valid32, out_valid64); end
      checks++; if (in_ready32 !== 1'b1 || in_ready64 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b/%b want 1", in_ready32, in_ready64); end
      checks++; if (out_imm32 !== '0 || out_imm64 !== '0) begin errors++; $display("FAIL reset_imm: got %h/%h want 0", out_imm32, out_imm64); end
      checks++; if (out_fmt32 !== FMT_NONE || out_fmt64 !== FMT_NONE) begin errors++; $display("FAIL reset_fmt: got %0d/%0d want 0", out_fmt32, out_fmt64); end
      checks++; if (out_illegal32 !== 1'b0 || out_illegal64 !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b/%b want 0", out_illegal32, out_illegal64); end
      checks++; if (out_tag32 !== '0 || out_tag64 !== '0) begin errors++; $display("FAIL reset_tag: got %h/%h want 0", out_tag32, out_tag64); end
    end
    rst = 1'b0;
  endtask

  task automatic apply_one(input logic [31:0] inst,
                           input logic [31:0] i32, input logic [2:0] f32, input logic l32,
                           input logic [63:0] i64, input logic [2:0] f64, input logic l64);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_inst   = inst;
    in_tag    = $urandom;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid32 !== 1'b1 || out_imm32 !== i32 || out_fmt32 !== f32 || out_illegal32 !== l32) begin
      errors++;
      $display("FAIL directed32 %h: got v=%b imm=%h fmt=%0d ill=%b want v=1 imm=%h fmt=%0d ill=%b",
               inst, out_valid32, out_imm32, out_fmt32, out_illegal32, i32, f32, l32);
    end
    checks++;
    if (out_valid64 !== 1'b1 || out_imm64 !== i64 || out_fmt64 !== f64 || out_illegal64 !== l64) begin
      errors++;
      $display("FAIL directed64 %h: got v=%b imm=%h fmt=%0d ill=%b want v=1 imm=%h fmt=%0d ill=%b",
               inst, out_valid64, out_imm64, out_fmt64, out_illegal64, i64, f64, l64);
    end
    step();
  endtask

  task automatic test_directed();
    apply_one(32'hFFF00093, 32'hFFFFFFFF, FMT_I, 1'b0, 64'hFFFFFFFFFFFFFFFF, FMT_I, 1'b0);
    apply_one(32'h0080006F, 32'h00000008, FMT_J, 1'b0, 64'h0000000000000008, FMT_J, 1'b0);
    apply_one(32'hFE20AE23, 32'hFFFFFFFC, FMT_S, 1'b0, 64'hFFFFFFFFFFFFFFFC, FMT_S, 1'b0);
    apply_one(32'h800000B7, 32'h80000000, FMT_U, 1'b0, 64'hFFFFFFFF80000000, FMT_U, 1'b0);
    apply_one(32'h00A0011B, 32'h00000000, FMT_NONE, 1'b1, 64'h000000000000000A, FMT_I, 1'b0);
    apply_one(32'h0000007F, 32'h00000000, FMT_NONE, 1'b1, 64'h0, FMT_NONE, 1'b1);
    apply_one(32'h00000000, 32'h00000000, FMT_NONE, 1'b1, 64'h0, FMT_NONE, 1'b1);
  endtask

  task automatic test_stall_stream();
    int next = 1;
    int emitted = 0;
    int cycles = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_tag  = next;
      in_inst = rand_inst();
      step();
      if (fire_in) next++;
      checks++;
      if (in_ready32 !== (next <= 2)) begin
        errors++;
        $display("FAIL stall_in_ready after %0d accepts: got %b want %b", next - 1, in_ready32, next <= 2);
      end
    end
    out_ready = 1'b1;
    while (emitted < 6 && cycles < 40) begin
      in_valid = (next <= 6);
      in_tag   = next;
      in_inst  = rand_inst();
      step();
      if (fire_in) next++;
      if (fire_out) emitted++;
      cycles++;
    end
    in_valid = 1'b0;
    checks++;
    if (emitted != 6 || cycles != 6) begin
      errors++;
      $display("FAIL stream_gapless: got %0d entries in %0d cycles want 6 in 6", emitted, cycles);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_tag    = 32'd100;
    in_inst   = rand_inst();
    step();
    in_tag  = 32'd101;
    in_inst = rand_inst();
    flush   = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0 || in_ready32 !== 1'b1 || in_ready64 !== 1'b1) begin
      errors++;
      $display("FAIL flush_clear: got out_valid=%b/%b in_ready=%b/%b want 0/0 1/1",
               out_valid32, out_valid64, in_ready32, in_ready64);
    end
    out_ready = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int t = 200; t < 202; t++) begin
      in_tag  = t;
      in_inst = rand_inst();
      step();
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0 || in_ready32 !== 1'b1 || in_ready64 !== 1'b1 ||
        out_tag32 !== '0 || out_imm64 !== '0 || out_fmt32 !== FMT_NONE || out_illegal64 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got v=%b/%b rdy=%b/%b tag=%h imm=%h fmt=%0d ill=%b want all cleared, ready 1",
               out_valid32, out_valid64, in_ready32, in_ready64, out_tag32, out_imm64, out_fmt32, out_illegal64);
    end
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_tag    = 32'd202;
    in_inst   = rand_inst();
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid32 !== 1'b1 || out_tag32 !== 32'd202 || out_valid64 !== 1'b1 || out_tag64 !== 32'd202) begin
      errors++;
      $display("FAIL post_reset_accept: got v=%b/%b tag=%h/%h want 1 tag 202",
               out_valid32, out_valid64, out_tag32, out_tag64);
    end
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_inst   = rand_inst();
      in_tag    = $urandom;
      step();
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_inst   = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    test_reset();
    test_directed();
    test_stall_stream();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, immediate width; the only legal values SHALL be 32 and 64.
REQ-002 Parameter TAG_W, default 32, width of the sideband tag (e.g. PC) carried with each instruction.
REQ-003 Port clk  input  1  single clock; all state SHALL be rising-edge triggered.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port flush  input  1  synchronous discard of all held entries.
REQ-006 Port in_valid  input  1  upstream holds an instruction.
REQ-007 Port in_ready  output  1  block accepts this cycle; SHALL be driven directly from a flop.
REQ-008 Port in_inst  input  32  raw instruction word.
REQ-009 Port in_tag  input  TAG_W  sideband, passed through unmodified.
REQ-010 Port out_valid  output  1  output entry present.
REQ-011 Port out_ready  input  1  downstream accepts.
REQ-012 Port out_imm  output  XLEN  sign/zero-extended immediate.
REQ-013 Port out_fmt  output  3  imm_fmt_e: I, S, B, U, J, Z (CSR zimm), NONE.
REQ-014 Port out_illegal  output  1  unsupported opcode, or inst[1:0] != 2'b11.
REQ-015 Port out_tag  output  TAG_W  tag of the entry on the output.

Function
REQ-016 Decode SHALL use inst[6:2] as follows:
- I: 00000 LOAD, 00001 LOAD-FP, 00100 OP-IMM, 11001 JALR; plus 00110 OP-IMM-32 only when XLEN=64.
- S: 01000 STORE, 01001 STORE-FP.
- B: 11000. U: 01101, 00101. J: 11011. Z: 11100.
REQ-017 Immediates SHALL be formed as follows:
- I: inst[31:20], sign-extended.
- S: inst[31:25],inst[11:7], sign-extended.
- B: inst[31],inst[7],inst[30:25],inst[11:8],0, sign-extended.
- J: inst[31],inst[19:12],inst[20],inst[30:21],0, sign-extended.
- U: inst[31:12],12'b0, sign-extended from bit 31 to XLEN.
- Z: inst[19:15], zero-extended.
REQ-018 Any other opcode, or inst[1:0] != 2'b11, SHALL give out_illegal=1, out_fmt=NONE and out_imm=0; no X SHALL ever reach out_imm.
REQ-019 Decode SHALL be performed before the output register; latency from in_valid&in_ready to out_valid SHALL be exactly 1 cycle.
REQ-020 Storage SHALL be one output register plus one skid register; sustained throughput SHALL be 1 entry/cycle while out_ready=1.
REQ-021 in_ready SHALL be 1 whenever the skid register is empty, regardless of the current out_ready.
REQ-022 Output register load rule, applied when out_valid=0 or out_ready=1:
- If the skid register is full, the output register SHALL load from the skid register and the skid register SHALL empty.
- Otherwise it SHALL load the accepted input, or go invalid if there is none.
REQ-023 An input accepted while out_valid=1 and out_ready=0 SHALL be written to the skid register, and in_ready SHALL fall the next cycle.
REQ-024 Order SHALL be preserved; no entry SHALL be dropped or duplicated.
REQ-025 Output fields SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 flush=1 SHALL clear both valid bits at the next edge and override any simultaneous accept.
REQ-027 in_ready SHALL be 1 in the cycle after a flush.

Reset
REQ-028 While rst=1, out_valid and the skid valid bit SHALL be 0 and in_ready SHALL be 1.
REQ-029 While rst=1, out_imm, out_fmt, out_illegal and out_tag SHALL be 0, with out_fmt=NONE.
REQ-030 Reset asserted mid-stall SHALL discard all entries; the first accept after release SHALL appear one cycle later.

Structure
REQ-031 imm_fmt_e and the opcode constants (OPC_LOAD, OPC_STORE_FP, ...) SHALL live in the shared package imm_pkg.
REQ-032 The combinational decode SHALL be the sub-module imm_decode, parametrised by XLEN.
REQ-033 Sequencing and skid logic SHALL reside in imm_gen_pipe.

Verification
REQ-034 Bench SHALL apply, with XLEN=32 and out_ready=1:
- 0xFFF00093 -> imm 0xFFFFFFFF, fmt I.
- 0x0080006F -> imm 0x00000008, fmt J.
- 0xFE20AE23 -> imm 0xFFFFFFFC, fmt S.
Each SHALL appear one cycle after acceptance.
REQ-035 Bench SHALL apply, with XLEN=64: 0x800000B7 -> imm 0xFFFFFFFF80000000, fmt U; 0x00A0011B -> fmt I, imm 10.
REQ-036 Bench SHALL apply 0x0000007F and 0x00000000 -> out_illegal=1, imm 0, fmt NONE.
REQ-037 Bench SHALL stream tags 1..6 with out_ready=0 for 3 cycles:
- in_ready SHALL fall after the second accept.
- Outputs SHALL emerge as 1..6 in order with no gaps once out_ready=1.
REQ-038 Bench SHALL assert flush in the same cycle as an accept while stalled -> out_valid=0 next cycle and no accepted tag ever appears.
REQ-039 Bench SHALL assert rst asynchronously mid-stream -> outputs clear immediately, without waiting for a clock edge.
